cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DIV_LOG2, default 21, meaning one CPU tick per 2^DIV_LOG2 clk_in cycles.
REQ-002 SHALL have parameter PC_W, default 10, meaning the width of the PC/breakpoint address.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the retired-tick counter.
REQ-004 SHALL have port clk_in, input, 1 bit: the single system clock.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: run/resume request, raw button level.
REQ-007 SHALL have port pause, input, 1 bit: hold CPU while high, raw switch level.
REQ-008 SHALL have port step, input, 1 bit: single-step request, raw button level.
REQ-009 SHALL have port cnt_clr, input, 1 bit: synchronous clear of cycle_cnt.
REQ-010 SHALL have port pc, input, PC_W bits: current CPU fetch address.
REQ-011 SHALL have port bp_en, input, 1 bit: breakpoint enable.
REQ-012 SHALL have port bp_addr, input, PC_W bits: breakpoint address.
REQ-013 SHALL have port cpu_ce, output, 1 bit: one-clk_in-cycle CPU clock-enable pulse.
REQ-014 SHALL have port run_state, output, 3 bits: current FSM state.
REQ-015 SHALL have port bp_hit, output, 1 bit: sticky flag, high while in BREAK.
REQ-016 SHALL have port cycle_cnt, output, CNT_W bits: number of cpu_ce pulses issued.

Function
REQ-017 SHALL pass start, pause and step each through a 2-flop synchronizer; start and step SHALL use rising-edge detection (sync stage 2 high, stage 3 low); pause SHALL be level-sensitive.
REQ-018 SHALL run a free DIV_LOG2-bit divider counter that wraps; tick is true in the cycle the counter is all ones.
REQ-019 SHALL encode the FSM as IDLE=0, RUN=1, PAUSE=2, STEP=3, BREAK=4; codes 5-7 SHALL return to IDLE.
REQ-020 IDLE SHALL move to RUN on a start rise; all other inputs SHALL be ignored in IDLE.
REQ-021 RUN SHALL move to PAUSE when synced pause is high, with priority over a breakpoint and over a tick in the same cycle (no cpu_ce).
REQ-022 RUN, on a tick with bp_en=1 and pc==bp_addr and no mask, SHALL move to BREAK and suppress that cpu_ce.
REQ-023 RUN SHALL otherwise assert cpu_ce on every tick.
REQ-024 PAUSE SHALL move to RUN when synced pause is low, and to STEP on a step rise while pause is high.
REQ-025 STEP SHALL assert cpu_ce on the next tick, ignoring the breakpoint, then move to PAUSE, or to BREAK if entered from BREAK.
REQ-026 BREAK SHALL move to RUN on a start rise, setting a one-shot mask so the first RUN tick ignores the breakpoint; a step rise SHALL move it to STEP.
REQ-027 Start rises in RUN, PAUSE or STEP, and step rises in RUN, SHALL be ignored.
REQ-028 cpu_ce SHALL be high for exactly one clk_in cycle per issued tick and never outside RUN or STEP.
REQ-029 cycle_cnt SHALL increment by 1 per cpu_ce and wrap modulo 2^CNT_W.
REQ-030 cnt_clr SHALL zero cycle_cnt, with priority over a coincident increment.
REQ-031 bp_hit SHALL equal (run_state==BREAK).

Reset
REQ-032 reset_n low SHALL asynchronously clear the divider, synchronizers, mask and cycle_cnt, set run_state=IDLE, and drive cpu_ce=0 and bp_hit=0.
REQ-033 Reset mid-tick or mid-STEP SHALL abort with no cpu_ce issued; first tick after release SHALL occur 2^DIV_LOG2 cycles later.

Configuration
REQ-034 With macro RUN_CTRL_BP_EN defined, breakpoint logic (REQ-022, REQ-026 mask, BREAK state) SHALL be compiled in.
REQ-035 Without RUN_CTRL_BP_EN, bp_en, bp_addr and pc SHALL be ignored, BREAK SHALL be unreachable, and bp_hit SHALL be constant 0.

Verification (DIV_LOG2=2, PC_W=10, CNT_W=8, RUN_CTRL_BP_EN defined)
REQ-036 Reset, start pulse -> run_state=1 within 4 cycles; cpu_ce then exactly every 4 cycles; cycle_cnt=10 after 10 pulses.
REQ-037 In RUN, raise pause -> state 2, no cpu_ce; three step pulses -> exactly 3 cpu_ce, each followed by state 2; drop pause -> state 1.
REQ-038 bp_en=1, bp_addr=0x008, pc ramps per cpu_ce -> state 4 at pc=0x008 with that tick suppressed, bp_hit=1; start -> one cpu_ce at pc=0x008, then RUN.
REQ-039 cycle_cnt=0xFF plus one cpu_ce -> 0x00; cnt_clr coincident with cpu_ce -> 0x00.
REQ-040 reset_n low during STEP wait -> cpu_ce=0, state 0, cycle_cnt=0 immediately, without a clock edge.
REQ-041 Without RUN_CTRL_BP_EN, repeat REQ-038 stimulus -> never state 4, bp_hit=0, cpu_ce uninterrupted.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step/breakpoint controller generating a divided CPU clock-enable.
// Breakpoint support is compiled in only when RUN_CTRL_BP_EN is defined.
module cpu_run_ctrl #(
    parameter int DIV_LOG2 = 21,
    parameter int PC_W     = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             cnt_clr,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_ce,
    output logic [2:0]       run_state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [DIV_LOG2-1:0] div_q, div_d;
    logic [2:0]          start_sync_q, start_sync_d;
    logic [2:0]          step_sync_q, step_sync_d;
    logic [1:0]          pause_sync_q, pause_sync_d;
    logic [2:0]          state_q, state_d;
    logic                mask_q, mask_d;
    logic                from_brk_q, from_brk_d;
    logic                cpu_ce_q, cpu_ce_d;
    logic                bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic tick_s;
    logic start_rise_s;
    logic step_rise_s;
    logic pause_s;
    logic bp_match_s;

    assign tick_s       = &div_q;
    assign start_rise_s = start_sync_q[1] & ~start_sync_q[2];
    assign step_rise_s  = step_sync_q[1] & ~step_sync_q[2];
    assign pause_s      = pause_sync_q[1];

`ifdef RUN_CTRL_BP_EN
    assign bp_match_s = bp_en && (pc == bp_addr);
`else
    logic unused_s;
    assign bp_match_s = 1'b0;
    assign unused_s   = bp_en ^ (^pc) ^ (^bp_addr);
`endif

    // Divider, synchronizer shift and counter next-values
    always_comb begin
        div_d        = div_q + DIV_LOG2'(1);
        start_sync_d = {start_sync_q[1:0], start};
        step_sync_d  = {step_sync_q[1:0], step};
        pause_sync_d = {pause_sync_q[0], pause};
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cpu_ce_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Run-control FSM; cpu_ce_d is only ever raised on a tick in RUN or STEP
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        from_brk_d = from_brk_q;
        cpu_ce_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise_s) state_d = ST_RUN;
                else              state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (pause_s) begin
                    state_d = ST_PAUSE;
                end else if (tick_s) begin
                    // The mask lets the first tick after resuming from BREAK pass the breakpoint
                    mask_d = 1'b0;
                    if (bp_match_s && !mask_q) state_d  = ST_BREAK;
                    else                       cpu_ce_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (!pause_s) begin
                    state_d = ST_RUN;
                end else if (step_rise_s) begin
                    state_d    = ST_STEP;
                    from_brk_d = 1'b0;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_STEP: begin
                if (tick_s) begin
                    cpu_ce_d = 1'b1;
                    state_d  = from_brk_q ? ST_BREAK : ST_PAUSE;
                end else begin
                    state_d = ST_STEP;
                end
            end
`ifdef RUN_CTRL_BP_EN
            ST_BREAK: begin
                if (start_rise_s) begin
                    state_d = ST_RUN;
                    mask_d  = 1'b1;
                end else if (step_rise_s) begin
                    state_d    = ST_STEP;
                    from_brk_d = 1'b1;
                end else begin
                    state_d = ST_BREAK;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef RUN_CTRL_BP_EN
        bp_hit_d = (state_d == ST_BREAK);
`else
        bp_hit_d = 1'b0;
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            div_q        <= {DIV_LOG2{1'b0}};
            start_sync_q <= 3'b000;
            step_sync_q  <= 3'b000;
            pause_sync_q <= 2'b00;
            state_q      <= ST_IDLE;
            mask_q       <= 1'b0;
            from_brk_q   <= 1'b0;
            cpu_ce_q     <= 1'b0;
            bp_hit_q     <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            div_q        <= div_d;
            start_sync_q <= start_sync_d;
            step_sync_q  <= step_sync_d;
            pause_sync_q <= pause_sync_d;
            state_q      <= state_d;
            mask_q       <= mask_d;
            from_brk_q   <= from_brk_d;
            cpu_ce_q     <= cpu_ce_d;
            bp_hit_q     <= bp_hit_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign run_state = state_q;
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl with DIV_LOG2=2, PC_W=10, CNT_W=8.
// Breakpoint expectations follow whether RUN_CTRL_BP_EN is defined for the build.
module tb_cpu_run_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic       step;
    logic       cnt_clr;
    logic [9:0] pc;
    logic       bp_en;
    logic [9:0] bp_addr;
    logic       cpu_ce;
    logic [2:0] run_state;
    logic       bp_hit;
    logic [7:0] cycle_cnt;

    int errors = 0;
    int checks = 0;

    cpu_run_ctrl #(.DIV_LOG2(2), .PC_W(10), .CNT_W(8)) dut (
        .clk_in    (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pause     (pause),
        .step      (step),
        .cnt_clr   (cnt_clr),
        .pc        (pc),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .cpu_ce    (cpu_ce),
        .run_state (run_state),
        .bp_hit    (bp_hit),
        .cycle_cnt (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ce(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (cpu_ce === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int limit, output int n, output bit ok);
        n  = 0;
        ok = (run_state === target);
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (run_state === target) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; pause = 1'b0; step = 1'b0;
        cnt_clr = 1'b0; pc = 10'd0; bp_en = 1'b0; bp_addr = 10'd0;
        cyc(3);
        checks++;
        if (run_state !== 3'd0 || cpu_ce !== 1'b0 || bp_hit !== 1'b0 || cycle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d ce=%b bp_hit=%b cnt=%0d, want 0 0 0 0",
                     run_state, cpu_ce, bp_hit, cycle_cnt);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle_ignore;
        pause = 1'b1; step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(10);
        checks++;
        if (run_state !== 3'd0 || cycle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL idle_ignore: state=%0d cnt=%0d, want 0 0", run_state, cycle_cnt);
        end
        pause = 1'b0;
        cyc(3);
    endtask

    task automatic test_run;
        int  n;
        bit  ok;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_state(3'd1, 8, n, ok);
        checks++;
        if (!ok || n + 1 > 4) begin
            errors++;
            $display("FAIL run_entry: reached=%b cycles=%0d, want 1 within 4", ok, n + 1);
        end
        wait_ce(8, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL first_ce: no cpu_ce within 8 cycles");
        end
        for (int p = 2; p <= 10; p++) begin
            wait_ce(8, n, ok);
            checks++;
            if (!ok || n != 4) begin
                errors++;
                $display("FAIL ce_period[%0d]: seen=%b gap=%0d, want 4", p, ok, n);
            end
        end
        checks++;
        if (cycle_cnt !== 8'd10) begin
            errors++;
            $display("FAIL cnt_after_10: got %0d want 10", cycle_cnt);
        end
    endtask

    task automatic test_pause_step;
        int n;
        bit ok;
        int ce_n;
        pause = 1'b1;
        wait_state(3'd2, 8, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pause_entry: state=%0d want 2", run_state);
        end
        ce_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) ce_n++;
        end
        checks++;
        if (ce_n != 0 || run_state !== 3'd2) begin
            errors++;
            $display("FAIL pause_hold: ce=%0d state=%0d, want 0 2", ce_n, run_state);
        end
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            ce_n = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (cpu_ce === 1'b1) ce_n++;
            end
            checks++;
            if (ce_n != 1 || run_state !== 3'd2) begin
                errors++;
                $display("FAIL step[%0d]: ce=%0d state=%0d, want 1 2", s, ce_n, run_state);
            end
        end
        pause = 1'b0;
        wait_state(3'd1, 8, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pause_release: state=%0d want 1", run_state);
        end
    endtask

    task automatic test_breakpoint;
        int n;
        bit ok;
        int ce_n;
        bit seen_brk;
        bit bad;
        pc = 10'd0; bp_addr = 10'h008; bp_en = 1'b1;
        ce_n = 0;
`ifdef RUN_CTRL_BP_EN
        seen_brk = 1'b0;
        n = 0;
        while (n < 100 && !seen_brk) begin
            @(negedge clk);
            n++;
            if (cpu_ce === 1'b1) begin
                ce_n++;
                pc = pc + 10'd1;
            end
            if (run_state === 3'd4) seen_brk = 1'b1;
        end
        checks++;
        if (!seen_brk || pc !== 10'h008 || ce_n != 8) begin
            errors++;
            $display("FAIL bp_entry: break=%b pc=%0d ce=%0d, want 1 8 8", seen_brk, pc, ce_n);
        end
        checks++;
        if (bp_hit !== 1'b1 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL bp_flag: bp_hit=%b ce=%b, want 1 0", bp_hit, cpu_ce);
        end
        ce_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) ce_n++;
        end
        checks++;
        if (ce_n != 0 || run_state !== 3'd4) begin
            errors++;
            $display("FAIL bp_hold: ce=%0d state=%0d, want 0 4", ce_n, run_state);
        end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_ce(16, n, ok);
        checks++;
        if (!ok || pc !== 10'h008 || run_state !== 3'd1 || bp_hit !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume: ce=%b pc=%0d state=%0d bp_hit=%b, want 1 8 1 0",
                     ok, pc, run_state, bp_hit);
        end
        pc = pc + 10'd1;
        wait_ce(8, n, ok);
        checks++;
        if (!ok || n != 4 || run_state !== 3'd1) begin
            errors++;
            $display("FAIL bp_after: ce=%b gap=%0d state=%0d, want 1 4 1", ok, n, run_state);
        end
`else
        bad = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) begin
                ce_n++;
                pc = pc + 10'd1;
            end
            if (run_state === 3'd4 || bp_hit !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL nobp_break: BREAK or bp_hit observed, want never");
        end
        checks++;
        if (ce_n != 20) begin
            errors++;
            $display("FAIL nobp_ce: got %0d pulses in 80 cycles want 20", ce_n);
        end
`endif
        bp_en = 1'b0;
    endtask

    task automatic test_counter;
        int n;
        bit ok;
        int ce_n;
        wait_ce(8, n, ok);
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        checks++;
        if (!ok || cycle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_clr: got %0d want 0", cycle_cnt);
        end
        ce_n = 0;
        n = 0;
        while (ce_n < 255 && n < 1100) begin
            @(negedge clk);
            n++;
            if (cpu_ce === 1'b1) ce_n++;
        end
        checks++;
        if (ce_n != 255 || cycle_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL cnt_ff: pulses=%0d cnt=0x%02h, want 255 0xFF", ce_n, cycle_cnt);
        end
        wait_ce(8, n, ok);
        checks++;
        if (!ok || cycle_cnt !== 8'h00) begin
            errors++;
            $display("FAIL cnt_wrap: got 0x%02h want 0x00", cycle_cnt);
        end
        cyc(3);
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        checks++;
        if (cpu_ce !== 1'b1 || cycle_cnt !== 8'h00) begin
            errors++;
            $display("FAIL cnt_clr_coincident: ce=%b cnt=0x%02h, want 1 0x00", cpu_ce, cycle_cnt);
        end
        wait_ce(8, n, ok);
        checks++;
        if (!ok || cycle_cnt !== 8'h01) begin
            errors++;
            $display("FAIL cnt_after_clr: got 0x%02h want 0x01", cycle_cnt);
        end
    endtask

    task automatic test_reset_step;
        int n;
        bit ok;
        pause = 1'b1;
        wait_state(3'd2, 8, n, ok);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        wait_state(3'd3, 8, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL step_entry: state=%0d want 3", run_state);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (cpu_ce !== 1'b0 || run_state !== 3'd0 || cycle_cnt !== 8'd0 || bp_hit !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ce=%b state=%0d cnt=%0d bp_hit=%b, want 0 0 0 0",
                     cpu_ce, run_state, cycle_cnt, bp_hit);
        end
        cyc(3);
        pause = 1'b0;
        reset_n = 1'b1;
        cyc(8);
        checks++;
        if (run_state !== 3'd0 || cycle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_idle: state=%0d cnt=%0d, want 0 0", run_state, cycle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_run();
        test_pause_step();
        test_breakpoint();
        test_counter();
        test_reset_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
